spike_route_tcam: RTL

Parametrised TCAM routing table for the spike-packet path: maps an incoming packet key to one or more destination/weight pairs. Supports ternary match per entry, multicast fan-out (every matching entry is emitted, lowest index first), valid/ready handshakes on both sides, and a flush. Sits between the packet ingress and the neuron/synapse update stage, replacing the single-hit memory.

---
 rtl/spike_route_tcam_if.sv | 52 +++++
 rtl/spike_route_tcam.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_route_tcam_if.sv
`default_nettype none
// ============================================================================
//  Module      : spike_route_tcam_if
//  Description : Config, lookup and result bus of the spike routing TCAM.
//                The slave modport is the TCAM side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spike_route_tcam_if #(
    parameter int KEY_W    = 8,
    parameter int ID_W     = 4,
    parameter int WEIGHT_W = 4,
    parameter int WORDS    = 16,
    parameter int ADDR_W   = $clog2(WORDS)
);
    logic                cfg_we;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [KEY_W-1:0]    cfg_key;
    logic [KEY_W-1:0]    cfg_care;
    logic [ID_W-1:0]     cfg_dst;
    logic [WEIGHT_W-1:0] cfg_weight;
    logic                cfg_vld;
    logic                flush;
    logic                cfg_ready;

    logic                in_valid;
    logic                in_ready;
    logic [KEY_W-1:0]    in_key;

    logic                out_valid;
    logic                out_ready;
    logic [ID_W-1:0]     out_dst;
    logic [WEIGHT_W-1:0] out_weight;
    logic [ADDR_W-1:0]   out_addr;
    logic                out_last;
    logic [ADDR_W:0]     hit_count;
    logic                miss;

    modport master (
        output cfg_we, cfg_addr, cfg_key, cfg_care, cfg_dst, cfg_weight, cfg_vld, flush,
        output in_valid, in_key, out_ready,
        input  cfg_ready, in_ready,
        input  out_valid, out_dst, out_weight, out_addr, out_last, hit_count, miss
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_key, cfg_care, cfg_dst, cfg_weight, cfg_vld, flush,
        input  in_valid, in_key, out_ready,
        output cfg_ready, in_ready,
        output out_valid, out_dst, out_weight, out_addr, out_last, hit_count, miss
    );
endinterface
`default_nettype wire

// File: rtl/spike_route_tcam.sv
`default_nettype none
// ============================================================================
//  Module      : spike_route_tcam
//  Description : Ternary routing table for spike packets. A lookup latches
//                every matching entry and streams them out lowest index
//                first, one per result handshake; a lookup with no match
//                produces a one-cycle miss pulse instead.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_route_tcam #(
    parameter int KEY_W    = 8,
    parameter int ID_W     = 4,
    parameter int WEIGHT_W = 4,
    parameter int WORDS    = 16,
    parameter int ADDR_W   = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spike_route_tcam_if.slave     bus
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SCAN = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;

    // Table storage; only the valid bits are reset
    logic [KEY_W-1:0]    r_key    [WORDS];
    logic [KEY_W-1:0]    r_care   [WORDS];
    logic [ID_W-1:0]     r_dst    [WORDS];
    logic [WEIGHT_W-1:0] r_weight [WORDS];
    logic [WORDS-1:0]    r_valid;

    // Remaining results of the lookup in progress, including the presented one
    logic [WORDS-1:0]    r_pending;

    logic                r_out_valid;
    logic [ID_W-1:0]     r_out_dst;
    logic [WEIGHT_W-1:0] r_out_weight;
    logic [ADDR_W-1:0]   r_out_addr;
    logic                r_out_last;
    logic [ADDR_W:0]     r_hit_count;
    logic                r_miss;

    logic [WORDS-1:0]    w_hit;
    logic [ADDR_W:0]     w_hit_pop;
    logic [WORDS-1:0]    w_pending_rest;
    logic [WORDS-1:0]    w_sel_vec;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_sel_last;

    logic                w_cfg_ready;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_pop;
    logic                w_cfg_wr;
    logic                w_flush;

    // Ternary compare of the incoming key against every valid entry
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < WORDS; i++) begin
            w_hit[i] = r_valid[i] && (((bus.in_key ^ r_key[i]) & r_care[i]) == '0);
        end
    end

    // Number of matching entries, latched as hit_count on acceptance
    always_comb begin
        w_hit_pop = '0;
        for (int i = 0; i < WORDS; i++) begin
            w_hit_pop = w_hit_pop + (ADDR_W+1)'(w_hit[i]);
        end
    end

    // Select the vector the next presented result comes from: fresh hits
    // when accepting a lookup, otherwise what remains after this handshake
    always_comb begin
        w_pending_rest = r_pending & ~(WORDS'(1) << r_out_addr);
        w_sel_vec      = (r_state == c_IDLE) ? w_hit : w_pending_rest;
        w_sel_last     = (w_sel_vec & (w_sel_vec - WORDS'(1))) == '0;
    end

    // Lowest set index of the selected vector
    always_comb begin
        w_sel_addr = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (w_sel_vec[i]) begin
                w_sel_addr = ADDR_W'(i);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: scan while results remain, misses stay in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept && (w_hit != '0)) begin
                    w_state_next = c_SCAN;
                end
            end
            c_SCAN: begin
                if (w_pop && (w_pending_rest == '0)) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // FSM outputs: config has priority over lookups, both blocked in SCAN
    always_comb begin
        w_cfg_ready = 1'b0;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        w_pop       = 1'b0;
        w_cfg_wr    = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_cfg_ready = 1'b1;
                w_in_ready  = !bus.cfg_we && !bus.flush;
                w_accept    = bus.in_valid && w_in_ready;
                w_flush     = bus.flush;
                w_cfg_wr    = bus.cfg_we && !bus.flush;
            end
            c_SCAN: begin
                w_pop = r_out_valid && bus.out_ready;
            end
            default: ;
        endcase
    end

    // Entry contents; not reset, they only matter once the valid bit is set
    always_ff @(posedge clk) begin
        if (w_cfg_wr) begin
            r_key[bus.cfg_addr]    <= bus.cfg_key;
            r_care[bus.cfg_addr]   <= bus.cfg_care;
            r_dst[bus.cfg_addr]    <= bus.cfg_dst;
            r_weight[bus.cfg_addr] <= bus.cfg_weight;
        end
    end

    // Valid bits, pending vector and registered result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= '0;
            r_pending    <= '0;
            r_out_valid  <= 1'b0;
            r_out_dst    <= '0;
            r_out_weight <= '0;
            r_out_addr   <= '0;
            r_out_last   <= 1'b0;
            r_hit_count  <= '0;
            r_miss       <= 1'b0;
        end else begin
            r_miss <= w_accept && (w_hit == '0);

            if (w_flush) begin
                r_valid <= '0;
            end else if (w_cfg_wr) begin
                r_valid[bus.cfg_addr] <= bus.cfg_vld;
            end

            if (w_accept) begin
                r_pending   <= w_hit;
                r_hit_count <= w_hit_pop;
                if (w_hit != '0) begin
                    r_out_valid  <= 1'b1;
                    r_out_addr   <= w_sel_addr;
                    r_out_dst    <= r_dst[w_sel_addr];
                    r_out_weight <= r_weight[w_sel_addr];
                    r_out_last   <= w_sel_last;
                end
            end else if (w_pop) begin
                r_pending <= w_pending_rest;
                if (w_pending_rest != '0) begin
                    r_out_addr   <= w_sel_addr;
                    r_out_dst    <= r_dst[w_sel_addr];
                    r_out_weight <= r_weight[w_sel_addr];
                    r_out_last   <= w_sel_last;
                end else begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            end
        end
    end

    assign bus.cfg_ready  = w_cfg_ready;
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_dst    = r_out_dst;
    assign bus.out_weight = r_out_weight;
    assign bus.out_addr   = r_out_addr;
    assign bus.out_last   = r_out_last;
    assign bus.hit_count  = r_hit_count;
    assign bus.miss       = r_miss;

endmodule
`default_nettype wire
